rob_retire: RTL and testbench
=============================

# rob_retire

Reorder buffer directly downstream of rename. Each renamed instruction is allocated an entry in program order, recording its architectural destination, new physical register and previous physical register. Execution units mark entries complete by tag. Entries retire strictly in order from the head, and each retirement returns the previous physical register to the rename free pool.

## Interface
Parameters:
- DEPTH, 16, number of entries; must be a power of two.
- IDX_W, 4, log2(DEPTH); width of the entry tag.
- PREG_W, 6, physical register index width.
- AREG_W, 5, architectural register index width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alloc_valid  in  1  rename presents an instruction this cycle.
- alloc_ready  out  1  = !full; an allocation occurs on an edge where alloc_valid && alloc_ready.
- alloc_has_dest  in  1  instruction writes a register.
- alloc_areg  in  AREG_W  architectural destination.
- alloc_preg  in  PREG_W  newly assigned physical destination.
- alloc_old_preg  in  PREG_W  previous mapping of alloc_areg.
- alloc_idx  out  IDX_W  combinational tail index; this is the tag of the entry being allocated.
- complete_valid  in  1  execution writeback strobe.
- complete_idx  in  IDX_W  tag of the completing entry.
- retire_valid  out  1  registered; one entry retired on the previous edge.
- retire_has_dest, retire_areg, retire_preg, retire_old_preg  out  1/AREG_W/PREG_W/PREG_W  fields of the retired entry.
- count  out  IDX_W+1  occupied entries.
- empty, full  out  1  count==0 and count==DEPTH.

## Operation
- Per-entry storage: valid, done, has_dest, areg, preg, old_preg.
- Pointers head and tail are IDX_W+1 bits wide; the extra MSB is the wrap bit.
  - empty when head==tail.
  - full when the low bits are equal and the MSBs differ.
  - The low IDX_W bits index storage and wrap naturally.
- Allocate: write the entry at tail[IDX_W-1:0] with valid=1, done=0 and the input fields, then tail+1.
- Complete: when complete_valid is high and entry[complete_idx].valid, set done=1.
  - A completion targeting an invalid entry is ignored.
  - A repeated completion has no further effect.
- Retire: on an edge where entry[head].valid && entry[head].done:
  - clear valid;
  - head+1;
  - register the entry fields onto retire_* and pulse retire_valid for one cycle.
- The free pool frees retire_old_preg only when retire_valid && retire_has_dest.
- count = tail - head, computed modulo 2^(IDX_W+1).

Simultaneous events:
- Allocate and retire on the same edge: both take effect and count is unchanged.
- Allocation is gated by full only. A retire in the same cycle does not open a slot until the next cycle.
- Completion of the head entry on edge E: the entry retires on edge E+1, not on E.
- A completion and an allocation to the same index cannot coincide, because an unallocated entry is invalid.

Reset:
- rst on any edge clears all valid and done bits and sets head=tail=0.
- Outputs after reset: retire_valid=0, all retire_* fields 0, count=0, empty=1, full=0, alloc_ready=1, alloc_idx=0.
- Reset overrides any allocate, complete or retire presented in the same cycle.

## Timing
- Allocation takes effect at the accepting edge. alloc_idx is valid combinationally in the same cycle.
- Completion sampled at edge E: earliest retire edge is E+1, and retire_valid is high in the cycle after E+1.
- With a stream of already-done entries, retirement throughput is one per cycle (two with the feature below).
- alloc_ready reflects full after the previous edge and has no combinational path from alloc_valid.

## Configuration
- ROB_DUAL_RETIRE_EN defined:
  - Adds a second retire port: retire1_valid, retire1_has_dest, retire1_areg, retire1_preg, retire1_old_preg.
  - If the head and head+1 entries are both valid and done, both retire on the same edge and head advances by 2.
  - Port 0 always carries the older entry.
  - head+1 never retires alone.
- Undefined: single retire port only; the retire1_* ports do not exist.

## Test plan
- Reset then idle: count=0, empty=1, alloc_ready=1, retire_valid=0, alloc_idx=0.
- Allocate tags 0,1,2 (areg 5/6/7, preg 32/33/34, old 5/6/7); complete 2 then 1, then 0 → no retire until tag 0 completes. Then three consecutive retire_valid pulses carry old_preg 5, 6, 7 in order (dual-retire build: 5+6 together, then 7).
- Fill 16 entries → full=1, alloc_ready=0. An alloc_valid while full leaves count=16. Complete and retire the head → alloc_ready=1 the next cycle; the new alloc gets alloc_idx=0 and tail wraps.
- Simultaneous allocate and head retire with count=8 → count stays 8, and head and tail both advance.
- complete_idx targeting an empty slot → no state change; a later allocation to that slot starts with done=0.
- Assert rst mid-stream with 5 entries pending → the next cycle shows count=0, retire_valid=0, and earlier completions are discarded.

Source files
------------

// File: rtl/rob_retire.sv
// rob_retire: in-order reorder buffer between rename and the free pool.
// Entries are allocated at the tail, marked done by tag, and retired in order
// from the head. Each retirement returns old_preg to the rename free pool.
// Optional feature: define ROB_DUAL_RETIRE_EN to retire two entries per edge.
// With it defined, the retire1_* port carries the younger entry.
module rob_retire #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned PREG_W = 6,
    parameter int unsigned AREG_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic              alloc_has_dest,
    input  logic [AREG_W-1:0] alloc_areg,
    input  logic [PREG_W-1:0] alloc_preg,
    input  logic [PREG_W-1:0] alloc_old_preg,
    output logic [IDX_W-1:0]  alloc_idx,
    input  logic              complete_valid,
    input  logic [IDX_W-1:0]  complete_idx,
    output logic              retire_valid,
    output logic              retire_has_dest,
    output logic [AREG_W-1:0] retire_areg,
    output logic [PREG_W-1:0] retire_preg,
    output logic [PREG_W-1:0] retire_old_preg,
`ifdef ROB_DUAL_RETIRE_EN
    output logic              retire1_valid,
    output logic              retire1_has_dest,
    output logic [AREG_W-1:0] retire1_areg,
    output logic [PREG_W-1:0] retire1_preg,
    output logic [PREG_W-1:0] retire1_old_preg,
`endif
    output logic [IDX_W:0]    count,
    output logic              empty,
    output logic              full
);

    localparam int unsigned PTR_W = IDX_W + 1;

    // Pointers carry an extra wrap bit so that full and empty can be told apart.
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  done_q;
    logic [DEPTH-1:0]  has_dest_q;
    logic [AREG_W-1:0] areg_q     [DEPTH];
    logic [PREG_W-1:0] preg_q     [DEPTH];
    logic [PREG_W-1:0] old_preg_q [DEPTH];

    logic [IDX_W-1:0]  head_idx;
    logic [IDX_W-1:0]  tail_idx;
    logic              alloc_fire;
    logic              ret0;

    assign head_idx    = head_q[IDX_W-1:0];
    assign tail_idx    = tail_q[IDX_W-1:0];
    assign empty       = (head_q == tail_q);
    assign full        = (head_q[IDX_W] != tail_q[IDX_W]) && (head_idx == tail_idx);
    assign count       = tail_q - head_q;
    assign alloc_ready = !full;
    assign alloc_idx   = tail_idx;
    assign alloc_fire  = alloc_valid && !full;
    assign ret0        = valid_q[head_idx] && done_q[head_idx];

`ifdef ROB_DUAL_RETIRE_EN
    logic [IDX_W-1:0]  head1_idx;
    logic              ret1;

    assign head1_idx = head_idx + IDX_W'(1);
    // The younger entry only retires alongside the head entry.
    assign ret1      = ret0 && valid_q[head1_idx] && done_q[head1_idx];
    assign head_d    = head_q + PTR_W'(ret0) + PTR_W'(ret1);
`else
    assign head_d    = head_q + PTR_W'(ret0);
`endif
    assign tail_d    = tail_q + PTR_W'(alloc_fire);

    // Entry status: completion by tag, clear on retire, fresh state on allocate.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            if (complete_valid && valid_q[complete_idx]) begin
                done_q[complete_idx] <= 1'b1;
            end
            if (ret0) begin
                valid_q[head_idx] <= 1'b0;
            end
`ifdef ROB_DUAL_RETIRE_EN
            if (ret1) begin
                valid_q[head1_idx] <= 1'b0;
            end
`endif
            // The tail slot is never valid while allocation is allowed.
            if (alloc_fire) begin
                valid_q[tail_idx] <= 1'b1;
                done_q[tail_idx]  <= 1'b0;
            end
        end
    end

    // Payload capture; contents are qualified by valid_q, so no reset is needed.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            has_dest_q[tail_idx] <= alloc_has_dest;
            areg_q[tail_idx]     <= alloc_areg;
            preg_q[tail_idx]     <= alloc_preg;
            old_preg_q[tail_idx] <= alloc_old_preg;
        end
    end

    // Pointer advance and registered retire port(s); fields read 0 on idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q           <= '0;
            tail_q           <= '0;
            retire_valid     <= 1'b0;
            retire_has_dest  <= 1'b0;
            retire_areg      <= '0;
            retire_preg      <= '0;
            retire_old_preg  <= '0;
`ifdef ROB_DUAL_RETIRE_EN
            retire1_valid    <= 1'b0;
            retire1_has_dest <= 1'b0;
            retire1_areg     <= '0;
            retire1_preg     <= '0;
            retire1_old_preg <= '0;
`endif
        end else begin
            head_q           <= head_d;
            tail_q           <= tail_d;
            retire_valid     <= ret0;
            retire_has_dest  <= ret0 && has_dest_q[head_idx];
            retire_areg      <= ret0 ? areg_q[head_idx]     : '0;
            retire_preg      <= ret0 ? preg_q[head_idx]     : '0;
            retire_old_preg  <= ret0 ? old_preg_q[head_idx] : '0;
`ifdef ROB_DUAL_RETIRE_EN
            retire1_valid    <= ret1;
            retire1_has_dest <= ret1 && has_dest_q[head1_idx];
            retire1_areg     <= ret1 ? areg_q[head1_idx]     : '0;
            retire1_preg     <= ret1 ? preg_q[head1_idx]     : '0;
            retire1_old_preg <= ret1 ? old_preg_q[head1_idx] : '0;
`endif
        end
    end

endmodule

// File: tb/tb_rob_retire.sv
// Testbench for rob_retire: a queue-based model of the reorder buffer, checked
// every cycle, plus directed scenarios with literal expectations.
// The ROB_DUAL_RETIRE_EN build is also supported.
module tb_rob_retire;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned PREG_W = 6;
    localparam int unsigned AREG_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              alloc_valid;
    logic              alloc_ready;
    logic              alloc_has_dest;
    logic [AREG_W-1:0] alloc_areg;
    logic [PREG_W-1:0] alloc_preg;
    logic [PREG_W-1:0] alloc_old_preg;
    logic [IDX_W-1:0]  alloc_idx;
    logic              complete_valid;
    logic [IDX_W-1:0]  complete_idx;
    logic              retire_valid;
    logic              retire_has_dest;
    logic [AREG_W-1:0] retire_areg;
    logic [PREG_W-1:0] retire_preg;
    logic [PREG_W-1:0] retire_old_preg;
`ifdef ROB_DUAL_RETIRE_EN
    logic              retire1_valid;
    logic              retire1_has_dest;
    logic [AREG_W-1:0] retire1_areg;
    logic [PREG_W-1:0] retire1_preg;
    logic [PREG_W-1:0] retire1_old_preg;
`endif
    logic [IDX_W:0]    count;
    logic              empty;
    logic              full;

    always #5 clk = ~clk;

    rob_retire #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PREG_W(PREG_W), .AREG_W(AREG_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_valid     (alloc_valid),
        .alloc_ready     (alloc_ready),
        .alloc_has_dest  (alloc_has_dest),
        .alloc_areg      (alloc_areg),
        .alloc_preg      (alloc_preg),
        .alloc_old_preg  (alloc_old_preg),
        .alloc_idx       (alloc_idx),
        .complete_valid  (complete_valid),
        .complete_idx    (complete_idx),
        .retire_valid    (retire_valid),
        .retire_has_dest (retire_has_dest),
        .retire_areg     (retire_areg),
        .retire_preg     (retire_preg),
        .retire_old_preg (retire_old_preg),
`ifdef ROB_DUAL_RETIRE_EN
        .retire1_valid   (retire1_valid),
        .retire1_has_dest(retire1_has_dest),
        .retire1_areg    (retire1_areg),
        .retire1_preg    (retire1_preg),
        .retire1_old_preg(retire1_old_preg),
`endif
        .count           (count),
        .empty           (empty),
        .full            (full)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model: in-flight instructions in program order, oldest first.
    typedef struct {
        int hd;
        int areg;
        int preg;
        int old;
        bit done;
    } ent_t;

    ent_t mq[$];
    int   head_tag = 0;
    int   e_rv, e_hd, e_areg, e_preg, e_old;
    int   e1_rv, e1_hd, e1_areg, e1_preg, e1_old;

    task automatic chk(input string nm, input integer act, input integer exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs presented to that edge.
    task automatic model_step();
        int   nret;
        int   p;
        ent_t e;
        e_rv = 0; e_hd = 0; e_areg = 0; e_preg = 0; e_old = 0;
        e1_rv = 0; e1_hd = 0; e1_areg = 0; e1_preg = 0; e1_old = 0;
        if (rst) begin
            mq.delete();
            head_tag = 0;
            return;
        end
        nret = 0;
        if (mq.size() > 0 && mq[0].done) nret = 1;
`ifdef ROB_DUAL_RETIRE_EN
        if (nret == 1 && mq.size() > 1 && mq[1].done) nret = 2;
`endif
        if (nret >= 1) begin
            e_rv = 1; e_hd = mq[0].hd; e_areg = mq[0].areg; e_preg = mq[0].preg; e_old = mq[0].old;
        end
        if (nret == 2) begin
            e1_rv = 1; e1_hd = mq[1].hd; e1_areg = mq[1].areg; e1_preg = mq[1].preg; e1_old = mq[1].old;
        end
        if (complete_valid) begin
            p = (int'(complete_idx) - head_tag + DEPTH) % DEPTH;
            if (p < mq.size()) mq[p].done = 1'b1;
        end
        if (alloc_valid && mq.size() < DEPTH) begin
            e.hd   = int'(alloc_has_dest);
            e.areg = int'(alloc_areg);
            e.preg = int'(alloc_preg);
            e.old  = int'(alloc_old_preg);
            e.done = 1'b0;
            mq.push_back(e);
        end
        for (int i = 0; i < nret; i++) void'(mq.pop_front());
        head_tag = (head_tag + nret) % DEPTH;
    endtask

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", count, mq.size());
            chk("empty", empty, (mq.size() == 0) ? 1 : 0);
            chk("full", full, (mq.size() == DEPTH) ? 1 : 0);
            chk("alloc_ready", alloc_ready, (mq.size() < DEPTH) ? 1 : 0);
            chk("alloc_idx", alloc_idx, (head_tag + mq.size()) % DEPTH);
            chk("retire_valid", retire_valid, e_rv);
            chk("retire_has_dest", retire_has_dest, e_hd);
            chk("retire_areg", retire_areg, e_areg);
            chk("retire_preg", retire_preg, e_preg);
            chk("retire_old_preg", retire_old_preg, e_old);
`ifdef ROB_DUAL_RETIRE_EN
            chk("retire1_valid", retire1_valid, e1_rv);
            chk("retire1_has_dest", retire1_has_dest, e1_hd);
            chk("retire1_areg", retire1_areg, e1_areg);
            chk("retire1_preg", retire1_preg, e1_preg);
            chk("retire1_old_preg", retire1_old_preg, e1_old);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input bit av, input bit hd, input int ar, input int pr, input int op,
                         input bit cv, input int ci);
        alloc_valid    = av;
        alloc_has_dest = hd;
        alloc_areg     = AREG_W'(ar);
        alloc_preg     = PREG_W'(pr);
        alloc_old_preg = PREG_W'(op);
        complete_valid = cv;
        complete_idx   = IDX_W'(ci);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        step();
        chk_en = 1'b1;
        do_reset();

        // Reset then idle
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_retire_valid", retire_valid, 0);
        chk("rst_alloc_idx", alloc_idx, 0);

        // Out-of-order completion, in-order retirement
        for (int i = 0; i < 3; i++) begin
            chk("order_alloc_idx", alloc_idx, i);
            drive(1'b1, 1'b1, 5 + i, 32 + i, 5 + i, 1'b0, 0);
            step();
        end
        drive(1'b0, 1'b0, 0, 0, 0, 1'b1, 2); step();
        chk("order_wait2", retire_valid, 0);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b1, 1); step();
        chk("order_wait1", retire_valid, 0);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b1, 0); step();
        chk("order_wait0", retire_valid, 0);
        idle(); step();
        chk("order_rv_a", retire_valid, 1);
        chk("order_old_a", retire_old_preg, 5);
`ifdef ROB_DUAL_RETIRE_EN
        chk("order_rv1_a", retire1_valid, 1);
        chk("order_old1_a", retire1_old_preg, 6);
        step();
        chk("order_rv_b", retire_valid, 1);
        chk("order_old_b", retire_old_preg, 7);
        chk("order_rv1_b", retire1_valid, 0);
`else
        step();
        chk("order_old_b", retire_old_preg, 6);
        step();
        chk("order_old_c", retire_old_preg, 7);
        chk("order_preg_c", retire_preg, 34);
`endif
        step();
        chk("order_done", retire_valid, 0);

        // Fill to full, blocked allocation, wrap of the tail
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, i, 16 + i, i, 1'b0, 0);
            step();
        end
        chk("full_flag", full, 1);
        chk("full_ready", alloc_ready, 0);
        drive(1'b1, 1'b1, 1, 2, 3, 1'b0, 0); step();
        chk("full_count", count, 16);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b1, 0); step();
        chk("full_before_retire", alloc_ready, 0);
        idle(); step();
        chk("full_after_retire", alloc_ready, 1);
        chk("wrap_idx", alloc_idx, 0);
        drive(1'b1, 1'b0, 9, 9, 9, 1'b0, 0); step();
        chk("wrap_count", count, 16);

        // Simultaneous allocate and retire at count 8
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, i, i, i, 1'b0, 0);
            step();
        end
        drive(1'b0, 1'b0, 0, 0, 0, 1'b1, 0); step();
        drive(1'b1, 1'b0, 3, 4, 5, 1'b0, 0); step();
        chk("simul_count", count, 8);
        chk("simul_rv", retire_valid, 1);
        chk("simul_idx", alloc_idx, 9);

        // Completion of an empty slot is ignored
        do_reset();
        drive(1'b0, 1'b0, 0, 0, 0, 1'b1, 3); step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, i, i, i, 1'b0, 0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 0, 0, 0, 1'b1, i);
            step();
        end
        idle();
        repeat (4) step();
        chk("stale_complete_count", count, 1);

        // Reset mid-stream discards pending entries and completions
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, i, i, i, 1'b0, 0);
            step();
        end
        drive(1'b0, 1'b0, 0, 0, 0, 1'b1, 3); step();
        drive(1'b0, 1'b0, 0, 0, 0, 1'b1, 4); step();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1, 1, 1, 1'b1, 0);
        step();
        rst = 1'b0;
        chk("midrst_count", count, 0);
        chk("midrst_rv", retire_valid, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, i, i, i, 1'b0, 0);
            step();
        end
        idle();
        repeat (3) step();
        chk("midrst_stale", count, 5);
        chk("midrst_stale_rv", retire_valid, 0);

        // Randomized traffic with phased allocation pressure
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int apct;
            int ci;
            apct = ((c / 500) % 2 == 0) ? 80 : 35;
            if ($urandom_range(0, 3) != 0)
                ci = (head_tag + $urandom_range(0, DEPTH - 1) % (mq.size() + 1)) % DEPTH;
            else
                ci = $urandom_range(0, DEPTH - 1);
            drive($urandom_range(0, 99) < apct, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63),
                  $urandom_range(0, 99) < 60, ci);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        idle();
        repeat (2) step();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
